proc_sequencer: RTL and testbench

- Program feeder and run controller for the 16-bit bus processor.
- Holds a small program RAM that the host loads through a write port.
- On Start, presents each instruction word on the processor's DIN with a one-cycle Run pulse, supplies the immediate word for mvi, waits for Done, then advances the program counter.
- Sits between host/test logic and the processor. It drives the processor's DIN/Run inputs and consumes its Done output.

---
 rtl/proc_pkg.sv | 23 ++
 rtl/prog_ram.sv | 26 ++
 rtl/proc_sequencer.sv | 136 +++++++++++++
 tb/tb_proc_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared opcode constants, field positions and sequencer state type for the
// 16-bit bus processor program feeder.
package proc_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT_DONE,
    S_ADVANCE,
    S_HALTED
  } seq_state_t;

endpackage

// File: rtl/prog_ram.sv
// Program RAM: synchronous write, two combinational read ports (current
// instruction and the word after it for mvi immediates).
module prog_ram #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/proc_sequencer.sv
// Program feeder and run controller: issues RAM words to the processor with a
// Run pulse, supplies mvi immediates, waits for Done and advances the pc.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              Start,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] pc,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mvi_q, mvi_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;

  logic [ADDR_W-1:0] pc_nxt;
  logic [DATA_W-1:0] rd_cur, rd_nxt;
  logic [2:0]        opc;

  assign pc_nxt = pc_q + 1'b1;

  prog_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk   (Clock),
    .we    (load_en & ~busy_q),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr0(pc_q),
    .raddr1(pc_nxt),
    .rdata0(rd_cur),
    .rdata1(rd_nxt)
  );

  assign opc = rd_cur[OPC_HI:OPC_LO];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    din_d   = din_q;
    cnt_d   = '0;
    mvi_d   = mvi_q;
    error_d = error_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          pc_d    = '0;
          error_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        din_d = rd_cur;
        mvi_d = (opc == OP_MVI);
        if (opc == OP_HALT)     state_d = S_HALTED;
        else if (opc == OP_MVI) state_d = S_IMM;
        else                    state_d = S_WAIT_DONE;
      end
      S_IMM: begin
        din_d   = rd_nxt;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        // Done wins over a timeout landing in the same cycle.
        if (Done) begin
          state_d = S_ADVANCE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_HALTED;
        end
      end
      S_ADVANCE: begin
        pc_d    = mvi_q ? pc_q + ADDR_W'(2) : pc_nxt;
        state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d inside {S_ISSUE, S_IMM, S_WAIT_DONE});
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      din_q    <= '0;
      cnt_q    <= '0;
      mvi_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      din_q    <= din_d;
      cnt_q    <= cnt_d;
      mvi_q    <= mvi_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  // Issue words come straight from RAM so a halt word can suppress Run in
  // its own cycle; din_q holds the last issued word between issues.
  assign Run    = (state_q == S_ISSUE) && (opc != OP_HALT);
  assign DIN    = (state_q == S_ISSUE) ? rd_cur :
                  (state_q == S_IMM)   ? rd_nxt : din_q;
  assign pc     = pc_q;
  assign Busy   = busy_q;
  assign Halted = halted_q;
  assign Error  = error_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: expected Run issues are queued by the
// stimulus; a negedge monitor pops and checks pc, DIN, immediate and spacing.
module tb_proc_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        Start = 1'b0;
  logic [15:0] DIN;
  logic        Run;
  logic        Done;
  logic [4:0]  pc;
  logic        Busy, Halted, Error;

  logic done_model = 1'b0;
  logic done_inj   = 1'b0;
  bit   model_en   = 1'b0;
  int   model_n    = 1;
  assign Done = done_model | done_inj;

  proc_sequencer #(
    .ADDR_W (5),
    .DATA_W (16),
    .TIMEOUT(15)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .Start    (Start),
    .DIN      (DIN),
    .Run      (Run),
    .Done     (Done),
    .pc       (pc),
    .Busy     (Busy),
    .Halted   (Halted),
    .Error    (Error)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  pc;
    logic [15:0] din;
    bit          has_imm;
    logic [15:0] imm;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [4:0] p, input logic [15:0] d,
                               input bit hi, input logic [15:0] im, input int gap);
    exp_t e;
    e.pc = p; e.din = d; e.has_imm = hi; e.imm = im; e.gap = gap;
    sb.push_back(e);
  endfunction

  // Monitor: every Run pulse must match the head of the scoreboard.
  int          cyc = 0;
  int          last_run = 0;
  bit          imm_pend = 0;
  logic [15:0] imm_exp;
  always @(negedge Clock) begin
    exp_t e;
    cyc++;
    if (imm_pend) begin
      imm_pend = 0;
      chk("imm_din", 32'(DIN), 32'(imm_exp));
      chk("imm_run_low", 32'(Run), 32'd0);
    end
    if (Run) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_run: got Run at pc=%0d DIN=%0h, want no Run", pc, DIN);
      end else begin
        e = sb.pop_front();
        chk("run_pc", 32'(pc), 32'(e.pc));
        chk("run_din", 32'(DIN), 32'(e.din));
        if (e.gap != 0) chk("run_gap", 32'(cyc - last_run), 32'(e.gap));
        if (e.has_imm) begin
          imm_pend = 1;
          imm_exp  = e.imm;
        end
      end
      last_run = cyc;
    end
  end

  // Processor model: Done in the model_n-th WAIT_DONE cycle after issue.
  always begin
    int k;
    @(negedge Clock);
    if (Run && model_en) begin
      k = model_n + ((DIN[15:13] == 3'b001) ? 1 : 0);
      repeat (k) @(posedge Clock);
      #1 done_model = 1'b1;
      @(posedge Clock);
      #1 done_model = 1'b0;
    end
  end

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    @(posedge Clock); #1;
    load_en   = 1'b0;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic wait_halt(input int limit, output int n);
    n = 0;
    while (!Halted && n < limit) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("halt_reached", 32'(Halted), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    cycles(2);
    Reset = 1'b0;
    chk("rst_din", 32'(DIN), 32'd0);
    chk("rst_run", 32'(Run), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);

    // mvi R0,#5 then halt
    wr(5'd0, 16'h2000); wr(5'd1, 16'h0005); wr(5'd2, 16'hE000);
    model_en = 1; model_n = 1;
    push(5'd0, 16'h2000, 1, 16'h0005, 0);
    start_pulse();
    wait_halt(40, n);
    chk("t1_cycles", 32'(n), 32'd5);
    chk("t1_pc", 32'(pc), 32'd2);
    chk("t1_error", 32'(Error), 32'd0);
    chk("t1_busy", 32'(Busy), 32'd0);
    chk("t1_sb_drain", 32'(sb.size()), 32'd0);

    // add, sub, halt with Done in the 3rd wait cycle
    wr(5'd0, 16'h4080); wr(5'd1, 16'h6080); wr(5'd2, 16'hE000);
    model_n = 3;
    push(5'd0, 16'h4080, 0, 16'h0, 0);
    push(5'd1, 16'h6080, 0, 16'h0, 5);
    start_pulse();
    wait_halt(60, n);
    chk("t2_pc", 32'(pc), 32'd2);
    chk("t2_error", 32'(Error), 32'd0);
    chk("t2_sb_drain", 32'(sb.size()), 32'd0);

    // Done never arrives: timeout after 15 wait cycles
    wr(5'd0, 16'h0000);
    model_en = 0;
    push(5'd0, 16'h0000, 0, 16'h0, 0);
    start_pulse();
    wait_halt(40, n);
    chk("t3_cycles", 32'(n), 32'd16);
    chk("t3_error", 32'(Error), 32'd1);
    chk("t3_pc", 32'(pc), 32'd0);
    chk("t3_busy", 32'(Busy), 32'd0);
    push(5'd0, 16'h0000, 0, 16'h0, 0);
    start_pulse();
    chk("t3_error_clr", 32'(Error), 32'd0);
    chk("t3_busy_run", 32'(Busy), 32'd1);
    cycles(2);
    wr(5'd0, 16'hE000);  // must be dropped while busy
    wait_halt(40, n);
    chk("t3_error2", 32'(Error), 32'd1);
    push(5'd0, 16'h0000, 0, 16'h0, 0);
    start_pulse();
    wait_halt(40, n);
    chk("t3_readback_cycles", 32'(n), 32'd16);
    chk("t3_sb_drain", 32'(sb.size()), 32'd0);

    // mvi at address 31 takes its immediate from address 0, pc wraps to 1
    wr(5'd0, 16'h2000); wr(5'd1, 16'hE000);
    for (int unsigned a = 2; a <= 30; a++) wr(5'(a), 16'h4080);
    wr(5'd31, 16'h2400);
    model_en = 1; model_n = 1;
    push(5'd0, 16'h2000, 1, 16'hE000, 0);
    push(5'd2, 16'h4080, 0, 16'h0, 4);
    for (int unsigned a = 3; a <= 30; a++) push(5'(a), 16'h4080, 0, 16'h0, 3);
    push(5'd31, 16'h2400, 1, 16'h2000, 3);
    start_pulse();
    wait_halt(400, n);
    chk("t4_pc_wrap", 32'(pc), 32'd1);
    chk("t4_error", 32'(Error), 32'd0);
    chk("t4_sb_drain", 32'(sb.size()), 32'd0);

    // Reset in WAIT_DONE after the issue at pc=5
    push(5'd0, 16'h2000, 1, 16'hE000, 0);
    push(5'd2, 16'h4080, 0, 16'h0, 4);
    for (int unsigned a = 3; a <= 5; a++) push(5'(a), 16'h4080, 0, 16'h0, 3);
    start_pulse();
    k = 0;
    while (!(Run && pc == 5'd5) && k < 60) begin
      @(posedge Clock); #1;
      k++;
    end
    chk("t5_reached_pc5", 32'(pc), 32'd5);
    @(posedge Clock); #1;
    Reset = 1'b1;
    #1;
    chk("t5_rst_run", 32'(Run), 32'd0);
    chk("t5_rst_din", 32'(DIN), 32'd0);
    chk("t5_rst_pc", 32'(pc), 32'd0);
    chk("t5_rst_busy", 32'(Busy), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    model_en = 0;
    cycles(8);
    chk("t5_sb_drain", 32'(sb.size()), 32'd0);

    // Stray Done in IDLE/ISSUE/IMM and Start held while busy
    wr(5'd0, 16'h2000); wr(5'd1, 16'h0007); wr(5'd2, 16'hE000);
    done_inj = 1'b1;
    cycles(1);
    done_inj = 1'b0;
    chk("t6_idle_busy", 32'(Busy), 32'd0);
    chk("t6_idle_halted", 32'(Halted), 32'd0);
    push(5'd0, 16'h2000, 1, 16'h0007, 0);
    Start = 1'b1;
    cycles(1);
    done_inj = 1'b1;   // ISSUE
    cycles(1);         // IMM
    cycles(1);
    done_inj = 1'b0;   // first wait cycle
    chk("t6_wait_busy", 32'(Busy), 32'd1);
    chk("t6_wait_pc", 32'(pc), 32'd0);
    cycles(2);
    done_inj = 1'b1;
    Start = 1'b0;
    cycles(1);
    done_inj = 1'b0;   // ADVANCE
    chk("t6_adv_busy", 32'(Busy), 32'd0);
    wait_halt(20, n);
    chk("t6_cycles", 32'(n), 32'd2);
    chk("t6_pc", 32'(pc), 32'd2);
    chk("t6_error", 32'(Error), 32'd0);
    cycles(3);
    chk("t6_sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
